// File: rtl/mdu_pipelined.sv
// rtl/mdu_pipelined.sv - multi-cycle multiply/divide unit with HI/LO registers
// Results are formed from latched operands and committed to HI/LO on the last busy edge.
module mdu_pipelined #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t               r_state;
   state_t               w_next;
   logic [CW-1:0]        r_cnt;
   logic [3:0]           r_op;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic                 r_done;

   logic                 w_is_mult;
   logic                 w_is_div;
   logic                 w_idle;
   logic                 w_accept;
   logic                 w_last;
   logic [CW-1:0]        w_load;
   logic [2*WIDTH-1:0]   w_acc;
   logic [2*WIDTH-1:0]   w_prod_s;
   logic [2*WIDTH-1:0]   w_prod_u;
   logic signed [WIDTH-1:0] w_quo_s;
   logic signed [WIDTH-1:0] w_rem_s;
   logic [WIDTH-1:0]     w_quo_u;
   logic [WIDTH-1:0]     w_rem_u;
   logic                 w_div_zero;
   logic                 w_div_ovf;
   logic [2*WIDTH-1:0]   w_result;

   always_comb begin
      w_is_mult = 1'b0;
      w_is_div  = 1'b0;
      case (op)
         OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: w_is_mult = 1'b1;
         OP_DIV, OP_DIVU:                                         w_is_div  = 1'b1;
         default: ;
      endcase
   end

   assign w_idle   = (r_state == S_IDLE);
   assign w_accept = start && w_idle && (w_is_mult || w_is_div);
   assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(1));
   assign w_load   = w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_RUN;
         S_RUN:   if (w_last)   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Operands are widened before multiplying so the full 2W-bit product is kept.
   assign w_acc    = {r_hi, r_lo};
   assign w_prod_s = $signed({{WIDTH{r_a[WIDTH-1]}}, r_a}) * $signed({{WIDTH{r_b[WIDTH-1]}}, r_b});
   assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

   assign w_div_zero = (r_b == '0);
   assign w_div_ovf  = (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&r_b);
   assign w_quo_s    = $signed(r_a) / $signed(r_b);
   assign w_rem_s    = $signed(r_a) % $signed(r_b);
   assign w_quo_u    = r_a / r_b;
   assign w_rem_u    = r_a % r_b;

   // Divide by zero and unknown ops fall through to the current HI/LO value.
   always_comb begin
      w_result = w_acc;
      case (r_op)
         OP_MULT:  w_result = w_prod_s;
         OP_MULTU: w_result = w_prod_u;
         OP_MADD:  w_result = w_acc + w_prod_s;
         OP_MADDU: w_result = w_acc + w_prod_u;
         OP_MSUB:  w_result = w_acc - w_prod_s;
         OP_MSUBU: w_result = w_acc - w_prod_u;
         OP_DIV: begin
            if (w_div_ovf)
               w_result = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
            else if (!w_div_zero)
               w_result = {w_rem_s, w_quo_s};
         end
         OP_DIVU: begin
            if (!w_div_zero)
               w_result = {w_rem_u, w_quo_u};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt  <= '0;
         r_op   <= OP_NONE;
         r_a    <= '0;
         r_b    <= '0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_accept) begin
            r_op  <= op;
            r_a   <= operand_a;
            r_b   <= operand_b;
            r_cnt <= w_load;
         end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt - CW'(1);
         end
         if (start && w_idle && (op == OP_MTHI)) r_hi <= operand_a;
         if (start && w_idle && (op == OP_MTLO)) r_lo <= operand_a;
         if (w_last) {r_hi, r_lo} <= w_result;
      end
   end

   assign busy = (r_state == S_RUN);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
